alu_issue_ctrl: RTL

- Issue/write-back controller that drives the 8-bit ALU's operand and select inputs (DATA1, DATA2, SELECT) and retires its RESULT.
- Accepts one 32-bit instruction at a time over a valid/ready handshake and reads operands from an internal register file.
- Waits a fixed ALU settle time, then writes RESULT back to the destination register.
- Sits between the instruction source and the ALU; it is the initiator for the ALU.

---
 rtl/alu_issue_ctrl_pkg.sv | 40 ++++
 rtl/alu_issue_ctrl_if.sv | 26 ++
 rtl/alu_issue_ctrl_reg_file.sv | 38 +++
 rtl/alu_issue_ctrl.sv | 128 ++++++++++++
 4 files changed

// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue/write-back controller.
package alu_issue_ctrl_pkg;

  // Instruction opcodes; anything above OP_OR is illegal.
  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;

  // ALU SELECT encodings.
  localparam logic [2:0] ALU_FWD = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  // Field width of every instruction byte.
  localparam int FIELD_W = 8;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_e;

  // Instruction layout: [31:24] opcode, [23:16] dest, [15:8] src1, [7:0] src2/imm.
  typedef struct packed {
    logic [FIELD_W-1:0] opcode;
    logic [FIELD_W-1:0] dest;
    logic [FIELD_W-1:0] src1;
    logic [FIELD_W-1:0] src2;
  } instr_t;

  function automatic logic op_legal(input logic [7:0] op);
    return op <= OP_OR;
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Instruction handshake plus ALU operand/result bus.
// master: the controller (accepts instructions, initiates ALU operations).
// slave:  the environment (instruction source and the ALU itself).
interface alu_issue_ctrl_if #(
  parameter int DATA_W = 8
);
  logic [31:0]       INSTRUCTION;
  logic              INSTR_VALID;
  logic              INSTR_READY;
  logic [DATA_W-1:0] DATA1;
  logic [DATA_W-1:0] DATA2;
  logic [2:0]        SELECT;
  logic [DATA_W-1:0] RESULT;
  logic              WB_DONE;
  logic              ILLEGAL;

  modport master (
    input  INSTRUCTION, INSTR_VALID, RESULT,
    output INSTR_READY, DATA1, DATA2, SELECT, WB_DONE, ILLEGAL
  );

  modport slave (
    output INSTRUCTION, INSTR_VALID, RESULT,
    input  INSTR_READY, DATA1, DATA2, SELECT, WB_DONE, ILLEGAL
  );
endinterface

// File: rtl/alu_issue_ctrl_reg_file.sv
// Register file: two combinational operand reads, one debug read,
// one synchronous write port, synchronous clear.
module alu_issue_ctrl_reg_file #(
  parameter  int DATA_W  = 8,
  parameter  int REG_CNT = 8,
  localparam int AW      = $clog2(REG_CNT)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              WRITEENABLE,
  input  logic [AW-1:0]     WRITEADDR,
  input  logic [DATA_W-1:0] WRITEDATA,
  input  logic [AW-1:0]     rd1_addr,
  output logic [DATA_W-1:0] rd1_data,
  input  logic [AW-1:0]     rd2_addr,
  output logic [DATA_W-1:0] rd2_data,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] regs [REG_CNT];

  // Storage update: clear all entries on reset, otherwise single write.
  // NOTE: every entry is reset because software expects zeroed registers;
  // this keeps the array in flops rather than a RAM macro, fine at this size.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < REG_CNT; i++) regs[i] <= '0;
    end else if (WRITEENABLE) begin
      regs[WRITEADDR] <= WRITEDATA;
    end
  end

  assign rd1_data = regs[rd1_addr];
  assign rd2_data = regs[rd2_addr];
  assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/write-back controller: accepts one instruction, drives the ALU for
// ALU_LAT cycles, then writes RESULT back into the register file.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int REG_CNT = 8,
  parameter int ALU_LAT = 2
) (
  input  logic                       CLK,
  input  logic                       RESET,
  alu_issue_ctrl_if.master           bus,
  input  logic [$clog2(REG_CNT)-1:0] DBG_ADDR,
  output logic [DATA_W-1:0]          DBG_DATA
);

  localparam int         AW       = $clog2(REG_CNT);
  localparam logic [3:0] CNT_INIT = 4'(ALU_LAT - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q;
  logic [AW-1:0]     dest_q;
  logic [DATA_W-1:0] data1_q, data2_q;
  logic [2:0]        select_q;
  logic              illegal_q;

  instr_t            ins;
  logic              legal, accept, wr_en;
  logic [DATA_W-1:0] rd1, rd2, data2_nxt;
  logic [2:0]        select_nxt;
  logic              unused_fields;

  assign ins    = instr_t'(bus.INSTRUCTION);
  assign legal  = op_legal(ins.opcode);
  assign accept = (state_q == IDLE) && bus.INSTR_VALID;
  assign wr_en  = (state_q == EXEC) && (cnt_q == '0);

  // Register fields only use their low index bits.
  assign unused_fields = ^{ins.dest[FIELD_W-1:AW], ins.src1[FIELD_W-1:AW]};

  alu_issue_ctrl_reg_file #(
    .DATA_W  (DATA_W),
    .REG_CNT (REG_CNT)
  ) u_reg_file (
    .CLK         (CLK),
    .RESET       (RESET),
    .WRITEENABLE (wr_en),
    .WRITEADDR   (dest_q),
    .WRITEDATA   (bus.RESULT),
    .rd1_addr    (ins.src1[AW-1:0]),
    .rd1_data    (rd1),
    .rd2_addr    (ins.src2[AW-1:0]),
    .rd2_data    (rd2),
    .dbg_addr    (DBG_ADDR),
    .dbg_data    (DBG_DATA)
  );

  // Operand/select decode of the instruction currently offered.
  // NOTE: defaults come first so every path assigns every output and no latch forms.
  always_comb begin
    data2_nxt  = rd2;
    select_nxt = ALU_FWD;
    case (ins.opcode)
      OP_LOADI: data2_nxt = DATA_W'(ins.src2);
      OP_ADD:   select_nxt = ALU_ADD;
      OP_SUB: begin
        data2_nxt  = ~rd2 + DATA_W'(1);
        select_nxt = ALU_ADD;
      end
      OP_AND:   select_nxt = ALU_AND;
      OP_OR:    select_nxt = ALU_OR;
      default:  ;
    endcase
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge CLK) begin
    if (RESET) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; illegal opcodes leave the controller in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && legal) state_d = EXEC;
      EXEC:    if (cnt_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State-derived outputs.
  always_comb begin
    bus.INSTR_READY = (state_q == IDLE);
    bus.WB_DONE     = (state_q == DONE);
  end

  // Operand capture at accept, latency counter and illegal-opcode pulse.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      data1_q   <= '0;
      data2_q   <= '0;
      select_q  <= ALU_FWD;
      dest_q    <= '0;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= accept && !legal;
      if (accept && legal) begin
        data1_q  <= rd1;
        data2_q  <= data2_nxt;
        select_q <= select_nxt;
        dest_q   <= ins.dest[AW-1:0];
        cnt_q    <= CNT_INIT;
      end else if ((state_q == EXEC) && (cnt_q != '0)) begin
        cnt_q <= cnt_q - 4'd1;
      end
    end
  end

  assign bus.DATA1   = data1_q;
  assign bus.DATA2   = data2_q;
  assign bus.SELECT  = select_q;
  assign bus.ILLEGAL = illegal_q;

endmodule
